// File: rtl/fp_pkg.sv
// Shared widths, unpacked-operand record and FSM encoding for the floating point
// adder front end.
package fp_pkg;

   localparam int EXP_WIDTH_DEF      = 8;
   localparam int MANTISSA_WIDTH_DEF = 23;

   // Unpacked operand: mant carries the hidden bit above the stored fraction.
   typedef struct packed {
      logic                          sign;
      logic [EXP_WIDTH_DEF-1:0]      exp;
      logic [MANTISSA_WIDTH_DEF:0]   mant;
   } fp_unpacked_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_ADD   = 2'd2
   } align_state_t;

endpackage

// File: rtl/fp_operand_swap.sv
// Combinational unpack of two {sign,exp,frac} operands, ordered so the A side
// carries the larger magnitude; also returns the exponent difference.
module fp_operand_swap
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
   parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF
) (
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
   output logic                              sign_a,
   output logic [EXP_WIDTH-1:0]              exp_a,
   output logic [MANTISSA_WIDTH:0]           mant_a,
   output logic                              sign_b,
   output logic [MANTISSA_WIDTH:0]           mant_b,
   output logic [EXP_WIDTH-1:0]              exp_diff
);

   localparam int MAG_W = EXP_WIDTH + MANTISSA_WIDTH;

   logic                 swap;
   logic [MAG_W:0]       big_op;
   logic [MAG_W:0]       small_op;
   logic [EXP_WIDTH-1:0] exp_big;
   logic [EXP_WIDTH-1:0] exp_small;

   // {exp,frac} compares as one unsigned magnitude; ties keep A where it is.
   always_comb begin
      swap      = b_in[MAG_W-1:0] > a_in[MAG_W-1:0];
      big_op    = swap ? b_in : a_in;
      small_op  = swap ? a_in : b_in;
      exp_big   = big_op[MAG_W-1:MANTISSA_WIDTH];
      exp_small = small_op[MAG_W-1:MANTISSA_WIDTH];
      sign_a    = big_op[MAG_W];
      exp_a     = exp_big;
      mant_a    = {|exp_big, big_op[MANTISSA_WIDTH-1:0]};
      sign_b    = small_op[MAG_W];
      mant_b    = {|exp_small, small_op[MANTISSA_WIDTH-1:0]};
      exp_diff  = exp_big - exp_small;
   end

endmodule

// File: rtl/serial_align_adder.sv
// Multi-cycle align-and-add front end: aligns the smaller mantissa one bit per
// cycle, then adds or subtracts and pulses done_out with the raw magnitude.
module serial_align_adder
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
   parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_in,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
   output logic                              busy_out,
   output logic                              done_out,
   output logic                              sign_out,
   output logic [EXP_WIDTH-1:0]              expoent_out,
   output logic [MANTISSA_WIDTH+1:0]         result_out
);

   localparam int MW  = MANTISSA_WIDTH + 2;
   localparam int CW  = $clog2(MANTISSA_WIDTH + 2);

   // Handshake: a request is taken on any edge where start_in=1 and busy_out=0;
   // done_out is a single-cycle strobe and the result outputs stay valid after it.
   logic                 u_sign_a, u_sign_b;
   logic [EXP_WIDTH-1:0] u_exp_a, u_diff;
   logic [MANTISSA_WIDTH:0] u_mant_a, u_mant_b;

   fp_operand_swap #(
      .EXP_WIDTH      (EXP_WIDTH),
      .MANTISSA_WIDTH (MANTISSA_WIDTH)
   ) u_swap (
      .a_in     (a_in),
      .b_in     (b_in),
      .sign_a   (u_sign_a),
      .exp_a    (u_exp_a),
      .mant_a   (u_mant_a),
      .sign_b   (u_sign_b),
      .mant_b   (u_mant_b),
      .exp_diff (u_diff)
   );

   align_state_t         state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 sign_q, sign_d;
   logic [EXP_WIDTH-1:0] expo_q, expo_d;
   logic [MW-1:0]        result_q, result_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic [EXP_WIDTH-1:0] exp_a_q, exp_a_d;
   logic [MW-1:0]        mant_a_q, mant_a_d;
   logic [MW-1:0]        mant_b_q, mant_b_d;
   logic [CW-1:0]        k_q, k_d;

   logic [31:0]          diff_ext;
   logic                 clamp;
   logic [MW-1:0]        sum;

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sign_d   = sign_q;
      expo_d   = expo_q;
      result_d = result_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      exp_a_d  = exp_a_q;
      mant_a_d = mant_a_q;
      mant_b_d = mant_b_q;
      k_d      = k_q;

      // Beyond MANTISSA_WIDTH+1 the smaller operand cannot reach any kept bit.
      diff_ext = 32'(u_diff);
      clamp    = diff_ext > 32'(MANTISSA_WIDTH + 1);
      sum      = (sign_a_q == sign_b_q) ? (mant_a_q + mant_b_q) : (mant_a_q - mant_b_q);

      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               sign_a_d = u_sign_a;
               sign_b_d = u_sign_b;
               exp_a_d  = u_exp_a;
               mant_a_d = {1'b0, u_mant_a};
               mant_b_d = clamp ? '0 : {1'b0, u_mant_b};
               k_d      = clamp ? '0 : CW'(diff_ext);
               busy_d   = 1'b1;
               state_d  = (clamp || diff_ext == 32'd0) ? ST_ADD : ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            mant_b_d = mant_b_q >> 1;
            k_d      = k_q - 1'b1;
            if (k_q == CW'(1)) state_d = ST_ADD;
         end
         ST_ADD: begin
            result_d = sum;
            expo_d   = exp_a_q;
            sign_d   = (sum == '0) ? 1'b0 : sign_a_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sign_q   <= 1'b0;
         expo_q   <= '0;
         result_q <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         exp_a_q  <= '0;
         mant_a_q <= '0;
         mant_b_q <= '0;
         k_q      <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sign_q   <= sign_d;
         expo_q   <= expo_d;
         result_q <= result_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         exp_a_q  <= exp_a_d;
         mant_a_q <= mant_a_d;
         mant_b_q <= mant_b_d;
         k_q      <= k_d;
      end
   end

   assign busy_out    = busy_q;
   assign done_out    = done_q;
   assign sign_out    = sign_q;
   assign expoent_out = expo_q;
   assign result_out  = result_q;

endmodule
